// File: rtl/oled_pkg.sv
`default_nettype none
// ============================================================================
// Module  : oled_pkg
// Brief   : Shared fill-mode encodings, controller commands and fill FSM states.
// Revision: 1.0 - initial release
// ============================================================================
package oled_pkg;

    localparam logic [1:0] FILL_CLEAR   = 2'd0;
    localparam logic [1:0] FILL_SOLID   = 2'd1;
    localparam logic [1:0] FILL_CHECKER = 2'd2;
    localparam logic [1:0] FILL_USER    = 2'd3;

    localparam logic [7:0] CMD_PAGE_BASE  = 8'hB0;
    localparam logic [7:0] CMD_COLH_BASE  = 8'h10;
    localparam logic [7:0] PAT_CHECK_EVEN = 8'h55;
    localparam logic [7:0] PAT_CHECK_ODD  = 8'hAA;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_CHECK  = 4'd1,
        ST_CMD_PG = 4'd2,
        ST_CMD_CH = 4'd3,
        ST_CMD_CL = 4'd4,
        ST_DATA   = 4'd5,
        ST_NEXT   = 4'd6,
        ST_DONE   = 4'd7
    } fill_state_t;

    // States in which a byte is offered to the SPI sender.
    function automatic logic is_send_state(input fill_state_t st);
        return (st == ST_CMD_PG) || (st == ST_CMD_CH) ||
               (st == ST_CMD_CL) || (st == ST_DATA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/oled_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : oled_pattern_gen
// Brief   : Combinational fill pattern byte from mode, column parity and user byte.
// Revision: 1.0 - initial release
// ============================================================================
module oled_pattern_gen
    import oled_pkg::*;
(
    input  logic [1:0] mode,
    input  logic       col_lsb,
    input  logic [7:0] fill_byte,
    output logic [7:0] data
);

    always_comb begin
        data = 8'h00;
        case (mode)
            FILL_CLEAR:   data = 8'h00;
            FILL_SOLID:   data = 8'hFF;
            FILL_CHECKER: data = col_lsb ? PAT_CHECK_ODD : PAT_CHECK_EVEN;
            FILL_USER:    data = fill_byte;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/oled_fill.sv
`default_nettype none
// ============================================================================
// Module  : oled_fill
// Brief   : Page-addressed OLED region fill engine feeding the shared SPI byte sender.
// Revision: 1.0 - initial release
// ============================================================================
module oled_fill
    import oled_pkg::*;
#(
    parameter  int NUM_COLS   = 128,
    parameter  int NUM_PAGES  = 8,
    parameter  int COL_OFFSET = 2,
    localparam int COL_W      = $clog2(NUM_COLS),
    localparam int PAGE_W     = $clog2(NUM_PAGES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fill_start,
    input  logic [1:0]        fill_mode,
    input  logic [7:0]        fill_byte,
    input  logic [PAGE_W-1:0] page_lo,
    input  logic [PAGE_W-1:0] page_hi,
    input  logic [COL_W-1:0]  col_lo,
    input  logic [COL_W-1:0]  col_hi,
    input  logic              abort,
    output logic              spi_send,
    output logic [7:0]        spi_data,
    output logic              dc,
    input  logic              send_done,
    output logic              busy,
    output logic              fill_done,
    output logic              fill_err
);

    localparam logic [COL_W:0] c_num_cols = (COL_W+1)'(NUM_COLS);

    fill_state_t       r_state, w_state_nxt;
    logic [1:0]        r_mode;
    logic [7:0]        r_byte;
    logic [PAGE_W-1:0] r_page_lo, r_page_hi, r_page, w_page_nxt;
    logic [COL_W-1:0]  r_col_lo, r_col_hi, r_col, w_col_nxt;
    logic              r_abort, w_abort_nxt;
    logic              r_spi_send, w_send_nxt;
    logic [7:0]        r_spi_data, w_data_nxt;
    logic              r_dc, w_dc_nxt;
    logic              r_busy, r_fill_done, r_fill_err, w_err_nxt;

    logic              w_accept, w_sent, w_abort_now, w_range_bad;
    logic [7:0]        w_col_addr, w_pattern;

    assign w_accept    = (r_state == ST_IDLE) && fill_start;
    assign w_sent      = send_done && r_spi_send;
    assign w_abort_now = r_abort || abort;
    assign w_range_bad = (r_page_lo > r_page_hi) || (r_col_lo > r_col_hi) ||
                         ({1'b0, r_col_hi} >= c_num_cols);
    // Controller RAM address wraps at 8 bits after the panel offset is added.
    assign w_col_addr  = 8'(r_col_lo) + 8'(COL_OFFSET);

    oled_pattern_gen u_pattern (
        .mode      (r_mode),
        .col_lsb   (w_col_nxt[0]),
        .fill_byte (r_byte),
        .data      (w_pattern)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_mode      <= 2'd0;
            r_byte      <= 8'h00;
            r_page_lo   <= '0;
            r_page_hi   <= '0;
            r_col_lo    <= '0;
            r_col_hi    <= '0;
            r_page      <= '0;
            r_col       <= '0;
            r_abort     <= 1'b0;
            r_spi_send  <= 1'b0;
            r_spi_data  <= 8'h00;
            r_dc        <= 1'b0;
            r_busy      <= 1'b0;
            r_fill_done <= 1'b0;
            r_fill_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_page      <= w_page_nxt;
            r_col       <= w_col_nxt;
            r_abort     <= w_abort_nxt;
            r_spi_send  <= w_send_nxt;
            r_spi_data  <= w_data_nxt;
            r_dc        <= w_dc_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_fill_done <= (w_state_nxt == ST_DONE);
            r_fill_err  <= w_err_nxt;
            if (w_accept) begin
                r_mode    <= fill_mode;
                r_byte    <= fill_byte;
                r_page_lo <= page_lo;
                r_page_hi <= page_hi;
                r_col_lo  <= col_lo;
                r_col_hi  <= col_hi;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_page_nxt  = r_page;
        w_col_nxt   = r_col;
        w_abort_nxt = r_abort || (abort && (r_state != ST_IDLE));
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_abort_nxt = 1'b0;
                if (fill_start) w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_range_bad) begin
                    w_state_nxt = ST_DONE;
                    w_err_nxt   = 1'b1;
                end else if (w_abort_now) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_page_nxt  = r_page_lo;
                    w_col_nxt   = r_col_lo;
                    w_state_nxt = ST_CMD_PG;
                end
            end
            ST_CMD_PG: if (w_sent) w_state_nxt = w_abort_now ? ST_DONE : ST_CMD_CH;
            ST_CMD_CH: if (w_sent) w_state_nxt = w_abort_now ? ST_DONE : ST_CMD_CL;
            ST_CMD_CL: if (w_sent) w_state_nxt = w_abort_now ? ST_DONE : ST_DATA;
            ST_DATA: begin
                if (w_sent) begin
                    if (w_abort_now)          w_state_nxt = ST_DONE;
                    else if (r_col == r_col_hi) w_state_nxt = ST_NEXT;
                    else                      w_col_nxt   = r_col + COL_W'(1);
                end
            end
            ST_NEXT: begin
                if (w_abort_now || (r_page == r_page_hi)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_page_nxt  = r_page + PAGE_W'(1);
                    w_col_nxt   = r_col_lo;
                    w_state_nxt = ST_CMD_PG;
                end
            end
            ST_DONE: begin
                w_abort_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Byte fields follow the next state; spi_send skips the cycle after each
    // completed byte so the sender always sees a fresh rising request.
    always_comb begin
        w_send_nxt = is_send_state(w_state_nxt) && !w_sent;
        w_dc_nxt   = (w_state_nxt == ST_DATA);
        case (w_state_nxt)
            ST_CMD_PG: w_data_nxt = CMD_PAGE_BASE | 8'(w_page_nxt);
            ST_CMD_CH: w_data_nxt = CMD_COLH_BASE | {4'h0, w_col_addr[7:4]};
            ST_CMD_CL: w_data_nxt = {4'h0, w_col_addr[3:0]};
            ST_DATA:   w_data_nxt = w_pattern;
            default:   w_data_nxt = 8'h00;
        endcase
    end

    assign spi_send  = r_spi_send;
    assign spi_data  = r_spi_data;
    assign dc        = r_dc;
    assign busy      = r_busy;
    assign fill_done = r_fill_done;
    assign fill_err  = r_fill_err;

endmodule
`default_nettype wire

// File: tb/tb_oled_fill.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_oled_fill
// Brief   : Directed self-checking bench for oled_fill with an SPI ack model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_oled_fill;
    import oled_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a, start_b;
    logic [1:0] fill_mode;
    logic [7:0] fill_byte;
    logic [2:0] page_lo, page_hi;
    logic [6:0] col_lo, col_hi;
    logic       abort;
    logic       send_done = 1'b0;

    logic       spi_send_a, dc_a, busy_a, fill_done_a, fill_err_a;
    logic [7:0] spi_data_a;
    logic       spi_send_b, dc_b, busy_b, fill_done_b, fill_err_b;
    logic [7:0] spi_data_b;

    always #5 clk = ~clk;

    oled_fill u_dut (
        .clk(clk), .reset(reset), .fill_start(start_a), .fill_mode(fill_mode),
        .fill_byte(fill_byte), .page_lo(page_lo), .page_hi(page_hi),
        .col_lo(col_lo), .col_hi(col_hi), .abort(abort),
        .spi_send(spi_send_a), .spi_data(spi_data_a), .dc(dc_a),
        .send_done(send_done), .busy(busy_a), .fill_done(fill_done_a), .fill_err(fill_err_a)
    );

    oled_fill #(.COL_OFFSET(0)) u_dut_off0 (
        .clk(clk), .reset(reset), .fill_start(start_b), .fill_mode(fill_mode),
        .fill_byte(fill_byte), .page_lo(page_lo), .page_hi(page_hi),
        .col_lo(col_lo), .col_hi(col_hi), .abort(abort),
        .spi_send(spi_send_b), .spi_data(spi_data_b), .dc(dc_b),
        .send_done(send_done), .busy(busy_b), .fill_done(fill_done_b), .fill_err(fill_err_b)
    );

    // Only one DUT is ever active, so a single SPI model serves both.
    logic       w_any_send, w_dc;
    logic [7:0] w_data;
    assign w_any_send = spi_send_a | spi_send_b;
    assign w_dc       = spi_send_b ? dc_b : dc_a;
    assign w_data     = spi_send_b ? spi_data_b : spi_data_a;

    int n_checks = 0, n_fail = 0;
    logic [8:0] log_q[$];
    logic [8:0] exp_q[$];
    int rise_cnt = 0, done_cnt = 0, err_cnt = 0, cyc = 0, ack_cyc = 0, done_cyc = 0;
    int ack_timer = 0;
    logic prev_send = 1'b0;
    int log_base = 0, rise_base = 0, done_base = 0, err_base = 0;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            ack_timer = 0;
            prev_send = 1'b0;
            send_done <= 1'b0;
        end else begin
            send_done <= 1'b0;
            if (w_any_send && !prev_send) begin
                ack_timer = 5;
                rise_cnt++;
            end else if (ack_timer != 0) begin
                ack_timer--;
                if (ack_timer == 0 && w_any_send) begin
                    send_done <= 1'b1;
                    log_q.push_back({w_dc, w_data});
                    ack_cyc = cyc;
                end
            end
            prev_send = w_any_send;
        end
        if (fill_done_a || fill_done_b) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (fill_err_a || fill_err_b) err_cnt++;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] logged(input int idx);
        if (log_base + idx < log_q.size()) return {23'd0, log_q[log_base + idx]};
        return 32'hDEAD;
    endfunction

    task automatic start_fill(input logic use_b, input logic [1:0] m, input logic [7:0] b,
                              input logic [2:0] plo, input logic [2:0] phi,
                              input logic [6:0] clo, input logic [6:0] chi);
        @(negedge clk);
        fill_mode = m;
        fill_byte = b;
        page_lo   = plo;
        page_hi   = phi;
        col_lo    = clo;
        col_hi    = chi;
        log_base  = log_q.size();
        rise_base = rise_cnt;
        done_base = done_cnt;
        err_base  = err_cnt;
        if (use_b) start_b = 1'b1;
        else       start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == done_base && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check_value(tag, done_cnt - done_base, 1);
    endtask

    task automatic compare_log(input string tag);
        int bad = 0;
        check_value({tag, "_count"}, log_q.size() - log_base, exp_q.size());
        foreach (exp_q[i])
            if (logged(i) !== {23'd0, exp_q[i]}) bad++;
        check_value({tag, "_bytes"}, bad, 0);
    endtask

    logic [8:0] chk_seq [7];

    initial begin
        reset = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
        fill_mode = 2'd0; fill_byte = 8'h00;
        page_lo = 3'd0; page_hi = 3'd0; col_lo = 7'd0; col_hi = 7'd0;
        repeat (3) @(negedge clk);
        check_value("reset_outs_a", {spi_send_a, spi_data_a, dc_a, busy_a, fill_done_a, fill_err_a}, 0);
        check_value("reset_outs_b", {spi_send_b, spi_data_b, dc_b, busy_b, fill_done_b, fill_err_b}, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Full default frame, clear pattern
        start_fill(1'b0, FILL_CLEAR, 8'h00, 3'd0, 3'd7, 7'd0, 7'd127);
        check_value("busy_after_start", busy_a, 1);
        wait_done("frame_done", 20000);
        exp_q.delete();
        for (int p = 0; p < 8; p++) begin
            exp_q.push_back({1'b0, 8'hB0 + 8'(p)});
            exp_q.push_back(9'h010);
            exp_q.push_back(9'h002);
            for (int c = 0; c < 128; c++) exp_q.push_back(9'h100);
        end
        compare_log("frame");
        check_value("frame_rises", rise_cnt - rise_base, 1048);
        check_value("frame_err", err_cnt - err_base, 0);
        check_value("frame_idle_busy", busy_a, 0);

        // Checker pattern, single page, cols 10..13
        start_fill(1'b0, FILL_CHECKER, 8'h00, 3'd3, 3'd3, 7'd10, 7'd13);
        wait_done("chk_done", 2000);
        chk_seq = '{9'h0B3, 9'h010, 9'h00C, 9'h155, 9'h1AA, 9'h155, 9'h1AA};
        check_value("chk_count", log_q.size() - log_base, 7);
        for (int i = 0; i < 7; i++)
            check_value($sformatf("chk_byte%0d", i), logged(i), {23'd0, chk_seq[i]});
        check_value("chk_err", err_cnt - err_base, 0);

        // User byte, zero column offset, cols 120..127
        start_fill(1'b1, FILL_USER, 8'h3C, 3'd0, 3'd0, 7'd120, 7'd127);
        wait_done("user_done", 2000);
        exp_q.delete();
        exp_q.push_back(9'h0B0);
        exp_q.push_back(9'h017);
        exp_q.push_back(9'h008);
        for (int c = 0; c < 8; c++) exp_q.push_back(9'h13C);
        compare_log("user");

        // Inverted page range
        start_fill(1'b0, FILL_SOLID, 8'h00, 3'd5, 3'd2, 7'd0, 7'd3);
        check_value("inv_early_done", fill_done_a, 0);
        @(negedge clk);
        check_value("inv_done", fill_done_a, 1);
        check_value("inv_err", fill_err_a, 1);
        repeat (3) @(negedge clk);
        check_value("inv_no_send", rise_cnt - rise_base, 0);
        check_value("inv_busy", busy_a, 0);

        // Inverted column range
        start_fill(1'b0, FILL_SOLID, 8'h00, 3'd0, 3'd0, 7'd9, 7'd8);
        wait_done("invcol_done", 20);
        check_value("invcol_err", err_cnt - err_base, 1);

        // Abort during third data byte of page 1
        start_fill(1'b0, FILL_SOLID, 8'h00, 3'd0, 3'd2, 7'd0, 7'd9);
        for (int n = 0; n < 2000 && (log_q.size() - log_base) < 18; n++) @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done("abort_done", 2000);
        check_value("abort_count", log_q.size() - log_base, 19);
        check_value("abort_rises", rise_cnt - rise_base, 19);
        check_value("abort_last", logged(18), 32'h1FF);
        check_value("abort_latency", done_cyc - ack_cyc, 1);

        // Reset mid-DATA, then a clean frame with a start pulse while busy
        start_fill(1'b0, FILL_CLEAR, 8'h00, 3'd0, 3'd7, 7'd0, 7'd127);
        for (int n = 0; n < 2000 && (log_q.size() - log_base) < 6; n++) @(negedge clk);
        @(negedge clk);
        check_value("pre_reset_busy", busy_a, 1);
        reset = 1'b0;
        #1;
        check_value("mid_reset_outs", {spi_send_a, spi_data_a, dc_a, busy_a, fill_done_a, fill_err_a}, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        start_fill(1'b0, FILL_SOLID, 8'h00, 3'd7, 3'd7, 7'd0, 7'd1);
        for (int n = 0; n < 200 && (log_q.size() - log_base) < 2; n++) @(negedge clk);
        fill_mode = FILL_CLEAR;
        page_lo   = 3'd0;
        col_hi    = 7'd5;
        start_a   = 1'b1;
        @(negedge clk);
        start_a   = 1'b0;
        wait_done("restart_done", 2000);
        exp_q.delete();
        exp_q.push_back(9'h0B7);
        exp_q.push_back(9'h010);
        exp_q.push_back(9'h002);
        exp_q.push_back(9'h1FF);
        exp_q.push_back(9'h1FF);
        compare_log("restart");
        repeat (20) @(negedge clk);
        check_value("restart_quiet", rise_cnt - rise_base, 5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
